// File: rtl/tmu_pkg.sv
// rtl/tmu_pkg.sv - shared widths, FSM encoding and edge parameter types for the edge stepper
package tmu_pkg;

   localparam int COORD_W = 11;
   localparam int ERR_W   = 12;

   typedef logic [COORD_W-1:0] coord_t;
   typedef logic [ERR_W-1:0]   err_t;

   typedef enum logic {
      IDLE = 1'b0,
      EMIT = 1'b1
   } state_t;

   typedef struct packed {
      logic   positive;
      coord_t q;
      coord_t r;
   } step_t;

   // One triangle edge: per-coordinate steps for dest X, source U and source V.
   typedef struct packed {
      step_t  dx;
      step_t  du;
      step_t  dv;
      coord_t divisor;
   } edge_t;

   function automatic step_t coord_step(edge_t e, int idx);
      step_t s;
      case (idx)
         0:       s = e.dx;
         1:       s = e.du;
         default: s = e.dv;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/tmu_bresenham11.sv
// rtl/tmu_bresenham11.sv - one 11-bit Bresenham coordinate stepper with 12-bit error term
module tmu_bresenham11
   import tmu_pkg::*;
(
   input  logic               sys_clk,
   input  logic               sys_rst,
   input  logic               load,
   input  logic [COORD_W-1:0] load_value,
   input  logic               step,
   input  logic [COORD_W-1:0] q,
   input  logic [COORD_W-1:0] r,
   input  logic [COORD_W-1:0] divisor,
   input  logic               positive,
   output logic [COORD_W-1:0] value
);

   err_t   err;
   err_t   e_sum;
   err_t   e_next;
   logic   extra;
   coord_t delta;

   always_comb begin
      e_sum  = err + ERR_W'(r);
      extra  = (e_sum >= ERR_W'(divisor));
      e_next = extra ? (e_sum - ERR_W'(divisor)) : e_sum;
      delta  = q + COORD_W'(extra);
   end

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         value <= '0;
         err   <= '0;
      end else if (load) begin
         value <= load_value;
         err   <= '0;
      end else if (step) begin
         err   <= e_next;
         value <= positive ? (value + delta) : (value - delta);
      end
   end

endmodule

// File: rtl/tmu_edgestep.sv
// rtl/tmu_edgestep.sv - triangle edge walker emitting one scanline per beat; TMU_EDGESTEP_PERF_EN adds perf_spans
module tmu_edgestep
   import tmu_pkg::*;
(
   input  logic               sys_clk,
   input  logic               sys_rst,
   output logic               busy,
   input  logic               pipe_stb_i,
   output logic               pipe_ack_o,
   input  logic [COORD_W-1:0] A_S_X,
   input  logic [COORD_W-1:0] A_S_Y,
   input  logic [COORD_W-1:0] A_D_X,
   input  logic [COORD_W-1:0] A_D_Y,
   input  logic [COORD_W-1:0] B_S_X,
   input  logic [COORD_W-1:0] B_S_Y,
   input  logic [COORD_W-1:0] B_D_X,
   input  logic [COORD_W-1:0] B_D_Y,
   input  logic [COORD_W-1:0] C_D_Y,
   input  logic               dx1_positive,
   input  logic [COORD_W-1:0] dx1_q,
   input  logic [COORD_W-1:0] dx1_r,
   input  logic               du1_positive,
   input  logic [COORD_W-1:0] du1_q,
   input  logic [COORD_W-1:0] du1_r,
   input  logic               dv1_positive,
   input  logic [COORD_W-1:0] dv1_q,
   input  logic [COORD_W-1:0] dv1_r,
   input  logic               dx2_positive,
   input  logic [COORD_W-1:0] dx2_q,
   input  logic [COORD_W-1:0] dx2_r,
   input  logic               du2_positive,
   input  logic [COORD_W-1:0] du2_q,
   input  logic [COORD_W-1:0] du2_r,
   input  logic               dv2_positive,
   input  logic [COORD_W-1:0] dv2_q,
   input  logic [COORD_W-1:0] dv2_r,
   input  logic               dx3_positive,
   input  logic [COORD_W-1:0] dx3_q,
   input  logic [COORD_W-1:0] dx3_r,
   input  logic               du3_positive,
   input  logic [COORD_W-1:0] du3_q,
   input  logic [COORD_W-1:0] du3_r,
   input  logic               dv3_positive,
   input  logic [COORD_W-1:0] dv3_q,
   input  logic [COORD_W-1:0] dv3_r,
   input  logic [COORD_W-1:0] divisor1,
   input  logic [COORD_W-1:0] divisor2,
   input  logic [COORD_W-1:0] divisor3,
   output logic               pipe_stb_o,
   input  logic               pipe_ack_i,
   output logic [COORD_W-1:0] Y,
   output logic [COORD_W-1:0] LE_D_X,
   output logic [COORD_W-1:0] LE_S_X,
   output logic [COORD_W-1:0] LE_S_Y,
   output logic [COORD_W-1:0] SE_D_X,
   output logic [COORD_W-1:0] SE_S_X,
   output logic [COORD_W-1:0] SE_S_Y
`ifdef TMU_EDGESTEP_PERF_EN
   ,
   output logic [15:0]        perf_spans
`endif
);

   state_t state;
   edge_t  in_e  [3];
   edge_t  cap_e [3];
   coord_t cap_b_s_x, cap_b_s_y, cap_b_d_x, cap_b_d_y, cap_c_d_y;

   logic   accept, advance, se_at_b;
   coord_t y_next;
   edge_t  se_edge;
   step_t  le_par [3];
   step_t  se_par [3];
   coord_t le_init [3];
   coord_t se_init [3];
   coord_t le_val [3];
   coord_t se_val [3];

   assign in_e[0] = {dx1_positive, dx1_q, dx1_r, du1_positive, du1_q, du1_r,
                     dv1_positive, dv1_q, dv1_r, divisor1};
   assign in_e[1] = {dx2_positive, dx2_q, dx2_r, du2_positive, du2_q, du2_r,
                     dv2_positive, dv2_q, dv2_r, divisor2};
   assign in_e[2] = {dx3_positive, dx3_q, dx3_r, du3_positive, du3_q, du3_r,
                     dv3_positive, dv3_q, dv3_r, divisor3};

   assign busy       = (state != IDLE);
   assign pipe_ack_o = (state == IDLE);
   assign pipe_stb_o = (state == EMIT);

   // The short edge switches from edge1 to edge3 by snapping exactly onto vertex B.
   always_comb begin
      accept  = (state == IDLE) && pipe_stb_i;
      advance = (state == EMIT) && pipe_ack_i && (Y != cap_c_d_y);
      y_next  = Y + COORD_W'(1);
      se_at_b = (y_next == cap_b_d_y);
      se_edge = (y_next < cap_b_d_y) ? cap_e[0] : cap_e[2];
      le_init = '{A_D_X, A_S_X, A_S_Y};
      if (state == IDLE)
         se_init = (A_D_Y == B_D_Y) ? '{B_D_X, B_S_X, B_S_Y} : '{A_D_X, A_S_X, A_S_Y};
      else
         se_init = '{cap_b_d_x, cap_b_s_x, cap_b_s_y};
      for (int i = 0; i < 3; i++) begin
         le_par[i] = coord_step(cap_e[1], i);
         se_par[i] = coord_step(se_edge, i);
      end
   end

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state     <= IDLE;
         Y         <= '0;
         cap_e     <= '{default: '0};
         cap_b_s_x <= '0;
         cap_b_s_y <= '0;
         cap_b_d_x <= '0;
         cap_b_d_y <= '0;
         cap_c_d_y <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (pipe_stb_i) begin
                  state     <= EMIT;
                  Y         <= A_D_Y;
                  cap_e     <= in_e;
                  cap_b_s_x <= B_S_X;
                  cap_b_s_y <= B_S_Y;
                  cap_b_d_x <= B_D_X;
                  cap_b_d_y <= B_D_Y;
                  cap_c_d_y <= C_D_Y;
               end
            end
            EMIT: begin
               if (pipe_ack_i) begin
                  if (Y == cap_c_d_y)
                     state <= IDLE;
                  else
                     Y <= y_next;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   for (genvar i = 0; i < 3; i++) begin : g_coord
      tmu_bresenham11 u_le (
         .sys_clk    (sys_clk),
         .sys_rst    (sys_rst),
         .load       (accept),
         .load_value (le_init[i]),
         .step       (advance),
         .q          (le_par[i].q),
         .r          (le_par[i].r),
         .divisor    (cap_e[1].divisor),
         .positive   (le_par[i].positive),
         .value      (le_val[i])
      );
      tmu_bresenham11 u_se (
         .sys_clk    (sys_clk),
         .sys_rst    (sys_rst),
         .load       (accept || (advance && se_at_b)),
         .load_value (se_init[i]),
         .step       (advance),
         .q          (se_par[i].q),
         .r          (se_par[i].r),
         .divisor    (se_edge.divisor),
         .positive   (se_par[i].positive),
         .value      (se_val[i])
      );
   end

   assign LE_D_X = le_val[0];
   assign LE_S_X = le_val[1];
   assign LE_S_Y = le_val[2];
   assign SE_D_X = se_val[0];
   assign SE_S_X = se_val[1];
   assign SE_S_Y = se_val[2];

`ifdef TMU_EDGESTEP_PERF_EN
   always_ff @(posedge sys_clk) begin
      if (sys_rst)
         perf_spans <= '0;
      else if ((state == EMIT) && pipe_ack_i)
         perf_spans <= perf_spans + 16'd1;
   end
`endif

endmodule

// File: tb/tb_tmu_edgestep.sv
// tb/tb_tmu_edgestep.sv - self-checking bench for tmu_edgestep against a closed-form edge model
module tb_tmu_edgestep;

   logic        sys_clk = 1'b0;
   logic        sys_rst;
   logic        busy, pipe_stb_i, pipe_ack_o, pipe_stb_o, pipe_ack_i;
   logic [10:0] a_s_x, a_s_y, a_d_x, a_d_y, b_s_x, b_s_y, b_d_x, b_d_y, c_d_y;
   logic        pos [3][3];
   logic [10:0] qq [3][3];
   logic [10:0] rr [3][3];
   logic [10:0] dvs [3];
   logic [10:0] y_o, le_d_x, le_s_x, le_s_y, se_d_x, se_s_x, se_s_y;
`ifdef TMU_EDGESTEP_PERF_EN
   logic [15:0] perf_spans;
`endif

   int n_checks = 0;
   int n_fail   = 0;
   logic checking = 1'b0;
   int exp_y, beats, nexp, acked_total;
   int obs_le[$];
   int obs_se[$];

   always #5 sys_clk = ~sys_clk;

   tmu_edgestep dut (
      .sys_clk(sys_clk), .sys_rst(sys_rst), .busy(busy),
      .pipe_stb_i(pipe_stb_i), .pipe_ack_o(pipe_ack_o),
      .A_S_X(a_s_x), .A_S_Y(a_s_y), .A_D_X(a_d_x), .A_D_Y(a_d_y),
      .B_S_X(b_s_x), .B_S_Y(b_s_y), .B_D_X(b_d_x), .B_D_Y(b_d_y), .C_D_Y(c_d_y),
      .dx1_positive(pos[0][0]), .dx1_q(qq[0][0]), .dx1_r(rr[0][0]),
      .du1_positive(pos[0][1]), .du1_q(qq[0][1]), .du1_r(rr[0][1]),
      .dv1_positive(pos[0][2]), .dv1_q(qq[0][2]), .dv1_r(rr[0][2]),
      .dx2_positive(pos[1][0]), .dx2_q(qq[1][0]), .dx2_r(rr[1][0]),
      .du2_positive(pos[1][1]), .du2_q(qq[1][1]), .du2_r(rr[1][1]),
      .dv2_positive(pos[1][2]), .dv2_q(qq[1][2]), .dv2_r(rr[1][2]),
      .dx3_positive(pos[2][0]), .dx3_q(qq[2][0]), .dx3_r(rr[2][0]),
      .du3_positive(pos[2][1]), .du3_q(qq[2][1]), .du3_r(rr[2][1]),
      .dv3_positive(pos[2][2]), .dv3_q(qq[2][2]), .dv3_r(rr[2][2]),
      .divisor1(dvs[0]), .divisor2(dvs[1]), .divisor3(dvs[2]),
      .pipe_stb_o(pipe_stb_o), .pipe_ack_i(pipe_ack_i),
      .Y(y_o), .LE_D_X(le_d_x), .LE_S_X(le_s_x), .LE_S_Y(le_s_y),
      .SE_D_X(se_d_x), .SE_S_X(se_s_x), .SE_S_Y(se_s_y)
`ifdef TMU_EDGESTEP_PERF_EN
      , .perf_spans(perf_spans)
`endif
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Closed form: after k steps the value moved by k*q plus the number of error overflows.
   function automatic int model_val(int v0, bit p, int q, int r, int d, int k);
      int tot;
      tot = k * q + (k * r) / d;
      return p ? ((v0 + tot) & 2047) : ((v0 - tot) & 2047);
   endfunction

   function automatic int exp_out(int sel, int y);
      int c, e, v0, k;
      int av[3];
      int bv[3];
      av = '{int'(a_d_x), int'(a_s_x), int'(a_s_y)};
      bv = '{int'(b_d_x), int'(b_s_x), int'(b_s_y)};
      c = sel % 3;
      if (sel < 3) begin
         e = 1; v0 = av[c]; k = y - int'(a_d_y);
      end else if (y < int'(b_d_y)) begin
         e = 0; v0 = av[c]; k = y - int'(a_d_y);
      end else begin
         e = 2; v0 = bv[c]; k = y - int'(b_d_y);
      end
      return model_val(v0, pos[e][c], int'(qq[e][c]), int'(rr[e][c]), int'(dvs[e]), k);
   endfunction

   always @(negedge sys_clk) begin
      if (sys_rst)
         acked_total = 0;
      else if (pipe_stb_o && pipe_ack_i)
         acked_total++;
      if (checking) begin
         chk("stb", pipe_stb_o, beats < nexp);
         chk("busy", busy, beats < nexp);
         if (pipe_stb_o) begin
            chk("y", y_o, exp_y);
            chk("le_d_x", le_d_x, exp_out(0, exp_y));
            chk("le_s_x", le_s_x, exp_out(1, exp_y));
            chk("le_s_y", le_s_y, exp_out(2, exp_y));
            chk("se_d_x", se_d_x, exp_out(3, exp_y));
            chk("se_s_x", se_s_x, exp_out(4, exp_y));
            chk("se_s_y", se_s_y, exp_out(5, exp_y));
            if (pipe_ack_i) begin
               obs_le.push_back(int'(le_d_x));
               obs_se.push_back(int'(se_d_x));
               exp_y++;
               beats++;
            end
         end
      end
   end

   task automatic set_defaults();
      for (int e = 0; e < 3; e++) begin
         dvs[e] = 11'(5 + e);
         for (int c = 0; c < 3; c++) begin
            pos[e][c] = (((e + c) % 2) == 0);
            qq[e][c]  = 11'(e + c);
            rr[e][c]  = 11'(c + 1);
         end
      end
   endtask

   task automatic set_tri(input int adx, input int ady, input int asx, input int asy,
                          input int bdx, input int bdy, input int bsx, input int bsy, input int cdy);
      a_d_x = 11'(adx); a_d_y = 11'(ady); a_s_x = 11'(asx); a_s_y = 11'(asy);
      b_d_x = 11'(bdx); b_d_y = 11'(bdy); b_s_x = 11'(bsx); b_s_y = 11'(bsy);
      c_d_y = 11'(cdy);
   endtask

   // Called at posedge+1; returns at posedge+1 with the block idle.
   task automatic run_tri(input int hold_y, input int hold_n);
      int held;
      held = 0;
      nexp = int'(c_d_y) - int'(a_d_y) + 1;
      exp_y = int'(a_d_y);
      beats = 0;
      obs_le.delete();
      obs_se.delete();
      pipe_stb_i = 1'b1;
      pipe_ack_i = 1'b1;
      @(posedge sys_clk); #1;
      pipe_stb_i = 1'b0;
      checking = 1'b1;
      for (int cyc = 0; cyc < 64 && beats < nexp; cyc++) begin
         if (exp_y == hold_y && held < hold_n) begin
            pipe_ack_i = 1'b0;
            held++;
         end else begin
            pipe_ack_i = 1'b1;
         end
         @(posedge sys_clk); #1;
      end
      chk("beats", beats, nexp);
      @(negedge sys_clk);
      chk("ack_after_last", pipe_ack_o, 1);
      @(posedge sys_clk); #1;
      checking = 1'b0;
   endtask

   task automatic chk_seq(input string nm, input int got[$], input int e0, input int e1,
                          input int e2, input int e3, input int e4, input int n);
      int lit[5];
      lit = '{e0, e1, e2, e3, e4};
      chk({nm, "_len"}, got.size(), n);
      for (int i = 0; i < n && i < got.size(); i++)
         chk($sformatf("%s_%0d", nm, i), got[i], lit[i]);
   endtask

   initial begin
      sys_rst = 1'b1;
      pipe_stb_i = 1'b0;
      pipe_ack_i = 1'b0;
      set_defaults();
      set_tri(0, 0, 0, 0, 0, 0, 0, 0, 0);
      repeat (3) @(posedge sys_clk);
      #1 sys_rst = 1'b0;
      @(negedge sys_clk);
      chk("rst_stb", pipe_stb_o, 0);
      chk("rst_busy", busy, 0);
      chk("rst_ack", pipe_ack_o, 1);
      chk("rst_y", y_o, 0);
      chk("rst_le_d_x", le_d_x, 0);
      chk("rst_se_d_x", se_d_x, 0);
      @(posedge sys_clk); #1;

      // Long edge 10,11,12,13,15; du2 wraps below zero.
      set_tri(10, 10, 1, 7, 20, 12, 40, 50, 14);
      pos[1][0] = 1'b1; qq[1][0] = 11'd1; rr[1][0] = 11'd1; dvs[1] = 11'd4;
      pos[1][1] = 1'b0; qq[1][1] = 11'd2;
      run_tri(-1, 0);
      chk_seq("le_seq", obs_le, 10, 11, 12, 13, 15, 5);

      run_tri(11, 3);
      chk_seq("le_seq_stall", obs_le, 10, 11, 12, 13, 15, 5);

      set_defaults();
      set_tri(5, 20, 3, 4, 30, 20, 9, 9, 21);
      run_tri(-1, 0);
      chk("flat_top_first_se", obs_se.size() > 0 ? obs_se[0] : -1, 30);
      chk("flat_top_beats", obs_se.size(), 2);

      set_tri(7, 5, 8, 9, 70, 5, 71, 72, 5);
      run_tri(-1, 0);
      chk("single_beats", obs_le.size(), 1);

      set_tri(100, 0, 0, 0, 200, 1, 0, 0, 2);
      pos[1][0] = 1'b0; qq[1][0] = 11'd3; rr[1][0] = 11'd0;
      run_tri(-1, 0);
      chk_seq("le_neg", obs_le, 100, 97, 94, 0, 0, 3);

      set_defaults();
      set_tri(50, 10, 60, 70, 80, 12, 90, 100, 14);
      nexp = 5; exp_y = 10; beats = 0;
      pipe_stb_i = 1'b1;
      pipe_ack_i = 1'b1;
      @(posedge sys_clk); #1;
      pipe_stb_i = 1'b0;
      checking = 1'b1;
      for (int cyc = 0; cyc < 20 && exp_y != 12; cyc++) begin
         @(posedge sys_clk); #1;
      end
      chk("pre_rst_y", y_o, 12);
      checking = 1'b0;
      sys_rst = 1'b1;
      @(posedge sys_clk); #1;
      sys_rst = 1'b0;
      @(negedge sys_clk);
      chk("mid_rst_stb", pipe_stb_o, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_ack", pipe_ack_o, 1);
      chk("mid_rst_y", y_o, 0);
      chk("mid_rst_le", {le_d_x, le_s_x, le_s_y}, 0);
      chk("mid_rst_se", {se_d_x, se_s_x, se_s_y}, 0);
      @(posedge sys_clk); #1;

      set_tri(5, 20, 3, 4, 30, 20, 9, 9, 21);
      run_tri(-1, 0);
      chk("post_rst_beats", obs_se.size(), 2);
`ifdef TMU_EDGESTEP_PERF_EN
      chk("perf_spans", perf_spans, acked_total);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
